logicnet_lut_layer_pipe: RTL and testbench
==========================================

// Module: logicnet_lut_layer_pipe
// PURPOSE
//   Pipelined, runtime-programmable layer of NUM_NEURONS LogicNets neuron LUTs.
//   Each neuron maps its LUT_IN-bit fan-in word to a LUT_OUT-bit output through a
//   2^LUT_IN-entry truth table held in registers. Tables are loaded over a config
//   port. Layers chain via valid/ready, replacing fixed combinational ROM neurons.
// PARAMETERS
//   NUM_NEURONS  4  neurons (channels) in the layer
//   LUT_IN       8  fan-in bits per neuron (table depth 2^LUT_IN)
//   LUT_OUT      1  output bits per neuron
//   NSEL_W       $clog2(NUM_NEURONS+1)  width of cfg_neuron
// PORTS
//   clk         in   1                    clock, all logic on rising edge
//   rst         in   1                    asynchronous, active-high reset
//   s_valid     in   1                    input word valid
//   s_ready     out  1                    input word accepted when s_valid&s_ready
//   s_data      in   NUM_NEURONS*LUT_IN   fan-in words; neuron n = s_data[n*LUT_IN +: LUT_IN]
//   m_valid     out  1                    output word valid
//   m_ready     in   1                    downstream accepts when m_valid&m_ready
//   m_data      out  NUM_NEURONS*LUT_OUT  neuron n = m_data[n*LUT_OUT +: LUT_OUT]
//   cfg_we      in   1                    table write strobe
//   cfg_neuron  in   NSEL_W               neuron index for write
//   cfg_addr    in   LUT_IN               table entry index (= fan-in value)
//   cfg_data    in   LUT_OUT              entry value
//   cfg_err     out  1                    one-cycle pulse: write rejected
// BEHAVIOUR
//   - Reset (async, immediate): all table entries 0; stage valids v1,v2 = 0;
//     m_valid=0, m_data=0, cfg_err=0. s_ready=1 once rst deasserts. Reset mid-stream
//     drops all in-flight words; no output for them after release.
//   - Two-stage pipeline: S1 registers s_data (addresses); S2 registers lookup
//     result mem[n][addr_n] into m_data. Latency: accepted at edge k -> m_valid at k+2
//     when no stall. Throughput 1 word/cycle.
//   - Advance rules: adv2 = !v2 | m_ready; adv1 = !v1 | adv2; s_ready = adv1
//     (combinational from m_ready; no combinational s_valid->m_valid path).
//   - On adv2: v2<=v1; if v1 then m_data<=lookup(S1). On adv1: v1<=s_valid; S1 data
//     loaded only when s_valid. m_data holds stable while m_valid & !m_ready.
//   - Stall: with m_ready=0 the pipe buffers exactly 2 words (S1, S2) then s_ready=0.
//     No word lost, duplicated or reordered.
//   - Config write: cfg_we & cfg_neuron<NUM_NEURONS -> mem[cfg_neuron][cfg_addr]
//     <= cfg_data at that edge; visible to lookups captured on later edges.
//   - Collision: write and S2 capture of the same entry on the same edge -> S2
//     captures OLD value. Writes allowed at any time, regardless of pipe state.
//   - cfg_we with cfg_neuron>=NUM_NEURONS: no table change, cfg_err=1 next cycle
//     for exactly one cycle; otherwise cfg_err=0.
//   - Entry index equals fan-in value as unsigned binary (bit0 = LSB of fan-in).
// TESTING
//   1 Reset: pulse rst, send s_data=0 for all neurons -> m_valid 2 cycles later,
//     m_data=0; during rst m_valid=0, s_ready=0 released to 1 after.
//   2 Program: N0 addr 8'h00=1, 8'h20=0; N3 addr 8'hFF=1; send N0=8'h00,N3=8'hFF,
//     then N0=8'h20,N3=8'h00 -> m_data=4'b1001 then 4'b0000, latency 2, back-to-back.
//   3 Backpressure: m_ready=0, offer 4 words -> 2 accepted, s_ready=0; release
//     m_ready -> all 4 delivered in order, each once.
//   4 Collision: N1 addr 8'h05 =0; word N1=8'h05 in S1 while cfg writes 8'h05=1 on
//     capture edge -> output bit1=0; next identical word -> bit1=1.
//   5 Bad index: cfg_we with cfg_neuron=NUM_NEURONS -> cfg_err high 1 cycle,
//     subsequent lookups unchanged for all neurons.
//   6 Reset mid-stream: 2 words in flight, assert rst -> m_valid drops immediately,
//     tables read 0 afterwards, no stale word emitted after release.

Source files
------------

// File: rtl/logicnet_lut_layer_pipe.sv
`default_nettype none
// ============================================================================
// Module   : logicnet_lut_layer_pipe
// Brief    : Two-stage pipelined layer of runtime-programmable LogicNets
//            neuron LUTs with valid/ready streaming and a table-write port.
// Revision : 1.0 - initial release
// ============================================================================
module logicnet_lut_layer_pipe #(
    parameter int NUM_NEURONS = 4,
    parameter int LUT_IN      = 8,
    parameter int LUT_OUT     = 1,
    parameter int NSEL_W      = $clog2(NUM_NEURONS + 1)
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            s_valid,
    output logic                            s_ready,
    input  logic [NUM_NEURONS*LUT_IN-1:0]   s_data,
    output logic                            m_valid,
    input  logic                            m_ready,
    output logic [NUM_NEURONS*LUT_OUT-1:0]  m_data,
    input  logic                            cfg_we,
    input  logic [NSEL_W-1:0]               cfg_neuron,
    input  logic [LUT_IN-1:0]               cfg_addr,
    input  logic [LUT_OUT-1:0]              cfg_data,
    output logic                            cfg_err
);

    localparam int c_DEPTH = 1 << LUT_IN;
    localparam int c_DW    = NUM_NEURONS * LUT_IN;
    localparam int c_OW    = NUM_NEURONS * LUT_OUT;

    logic              r_v1;
    logic              r_v2;
    logic [c_DW-1:0]   r_s1;
    logic [c_OW-1:0]   r_m_data;
    logic              r_cfg_err;
    logic [c_OW-1:0]   w_lookup;
    logic              w_adv1;
    logic              w_adv2;
    logic              w_cfg_bad;

    // A stage may advance when it is empty or the stage after it advances.
    assign w_adv2    = !r_v2 || m_ready;
    assign w_adv1    = !r_v1 || w_adv2;
    // Held low while reset is applied so nothing is offered into a pipe being cleared.
    assign s_ready   = w_adv1 && !rst;
    assign m_valid   = r_v2;
    assign m_data    = r_m_data;
    assign cfg_err   = r_cfg_err;
    assign w_cfg_bad = cfg_we && (cfg_neuron >= NSEL_W'(NUM_NEURONS));

    // Stage 1: capture the fan-in words, which serve as table addresses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_v1 <= 1'b0;
            r_s1 <= '0;
        end else if (w_adv1) begin
            r_v1 <= s_valid;
            if (s_valid) begin
                r_s1 <= s_data;
            end
        end
    end

    // Stage 2: register the table lookup; output holds while stalled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_v2     <= 1'b0;
            r_m_data <= '0;
        end else if (w_adv2) begin
            r_v2 <= r_v1;
            if (r_v1) begin
                r_m_data <= w_lookup;
            end
        end
    end

    // Out-of-range neuron index on a write produces a single-cycle error pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cfg_err <= 1'b0;
        end else begin
            r_cfg_err <= w_cfg_bad;
        end
    end

    // One truth table per neuron. A write landing on the same edge as a stage-2
    // capture of that entry is not seen by the capture (old value is read).
    for (genvar n = 0; n < NUM_NEURONS; n++) begin : g_neuron
        logic [LUT_OUT-1:0] r_tbl [c_DEPTH];
        logic               w_we;

        assign w_we = cfg_we && (cfg_neuron == NSEL_W'(n));

        // Table storage: cleared on reset, written from the config port.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                for (int i = 0; i < c_DEPTH; i++) begin
                    r_tbl[i] <= '0;
                end
            end else if (w_we) begin
                r_tbl[cfg_addr] <= cfg_data;
            end
        end

        assign w_lookup[n*LUT_OUT +: LUT_OUT] = r_tbl[r_s1[n*LUT_IN +: LUT_IN]];
    end

endmodule
`default_nettype wire

// File: tb/tb_logicnet_lut_layer_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_logicnet_lut_layer_pipe
// Brief    : Self-checking bench for logicnet_lut_layer_pipe (4 x 8-in x 1-out).
// Revision : 1.0 - initial release
// ============================================================================
module tb_logicnet_lut_layer_pipe;

    logic        clk;
    logic        rst;
    logic        s_valid;
    logic        s_ready;
    logic [31:0] s_data;
    logic        m_valid;
    logic        m_ready;
    logic [3:0]  m_data;
    logic        cfg_we;
    logic [2:0]  cfg_neuron;
    logic [7:0]  cfg_addr;
    logic [0:0]  cfg_data;
    logic        cfg_err;

    logicnet_lut_layer_pipe #(
        .NUM_NEURONS (4),
        .LUT_IN      (8),
        .LUT_OUT     (1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .s_data     (s_data),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
        .cfg_we     (cfg_we),
        .cfg_neuron (cfg_neuron),
        .cfg_addr   (cfg_addr),
        .cfg_data   (cfg_data),
        .cfg_err    (cfg_err)
    );

    int          total = 0;
    int          bad   = 0;
    int          n_out = 0;
    bit          tbl [4][256];
    logic [3:0]  q [$];
    logic [3:0]  mon_exp;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: each neuron output is its table entry indexed by its fan-in byte.
    function automatic logic [3:0] model_out(input logic [31:0] d);
        logic [3:0] r;
        for (int n = 0; n < 4; n++) r[n] = tbl[n][d[n*8 +: 8]];
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_write(input int n, input int a, input bit d);
        cfg_we     = 1'b1;
        cfg_neuron = 3'(n);
        cfg_addr   = 8'(a);
        cfg_data   = d;
        if (n < 4) tbl[n][a] = d;
        tick();
        cfg_we = 1'b0;
    endtask

    task automatic drain();
        s_valid = 1'b0;
        m_ready = 1'b1;
        repeat (5) tick();
        chk("drain_empty", q.size(), 0);
    endtask

    task automatic random_traffic(input int cycles);
        for (int c = 0; c < cycles; c++) begin
            s_valid = 1'($urandom_range(0, 1));
            s_data  = $urandom;
            m_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        drain();
    endtask

    // Scoreboard: predicts the handshakes of the coming edge from stable signals.
    always @(negedge clk) begin
        if (rst) begin
            q.delete();
        end else begin
            if (m_valid && m_ready) begin
                if (q.size() == 0) begin
                    chk("spurious_m_valid", m_valid, 0);
                end else begin
                    mon_exp = q.pop_front();
                    chk("m_data_stream", m_data, mon_exp);
                    n_out++;
                end
            end
            if (s_valid && s_ready) q.push_back(model_out(s_data));
        end
    end

    initial begin
        int         i;
        int         guard;
        int         n0;
        bit         acc;
        logic [31:0] w [4];

        rst = 1'b1; s_valid = 0; s_data = 0; m_ready = 1; cfg_we = 0;
        cfg_neuron = 0; cfg_addr = 0; cfg_data = 0;
        for (int n = 0; n < 4; n++) for (int a = 0; a < 256; a++) tbl[n][a] = 0;

        // Reset state
        #3;
        chk("rst_m_valid", m_valid, 0);
        chk("rst_s_ready", s_ready, 0);
        chk("rst_m_data", m_data, 0);
        chk("rst_cfg_err", cfg_err, 0);
        tick(); tick();
        rst = 1'b0;
        #1;
        chk("rel_s_ready", s_ready, 1);

        // Test 1: zero word, latency
        s_valid = 1; s_data = 0;
        tick();
        s_valid = 0;
        chk("t1_lat_not_yet", m_valid, 0);
        tick();
        chk("t1_m_valid", m_valid, 1);
        chk("t1_m_data", m_data, 0);
        tick();

        // Test 2: program and back-to-back words
        cfg_write(0, 8'h00, 1);
        chk("t2_cfg_err_ok", cfg_err, 0);
        cfg_write(0, 8'h20, 0);
        cfg_write(3, 8'hFF, 1);
        s_valid = 1; s_data = {8'hFF, 8'h00, 8'h00, 8'h00};
        tick();
        s_data = {8'h00, 8'h00, 8'h00, 8'h20};
        tick();
        s_valid = 0;
        chk("t2_v_a", m_valid, 1);
        chk("t2_d_a", m_data, 4'b1001);
        tick();
        chk("t2_v_b", m_valid, 1);
        chk("t2_d_b", m_data, 4'b0000);
        tick();
        chk("t2_idle", m_valid, 0);

        // Test 3: backpressure holds exactly two words
        for (int k = 0; k < 4; k++) w[k] = $urandom;
        n0 = n_out;
        m_ready = 0;
        i = 0;
        repeat (6) begin
            s_valid = 1; s_data = w[i];
            #1;
            acc = s_ready;
            tick();
            if (acc) i++;
        end
        chk("t3_accepted", i, 2);
        chk("t3_s_ready_low", s_ready, 0);
        chk("t3_m_valid_held", m_valid, 1);
        m_ready = 1;
        guard = 0;
        while (i < 4 && guard < 10) begin
            s_valid = 1; s_data = w[i];
            #1;
            acc = s_ready;
            tick();
            if (acc) i++;
            guard++;
        end
        chk("t3_all_sent", i, 4);
        drain();
        chk("t3_delivered", n_out - n0, 4);

        // Randomized tables and traffic
        for (int r = 0; r < 2; r++) begin
            for (int n = 0; n < 4; n++)
                for (int a = 0; a < 256; a++)
                    cfg_write(n, a, 1'($urandom_range(0, 1)));
            random_traffic(150);
        end

        // Test 4: write/capture collision
        cfg_write(1, 8'h05, 0);
        s_valid = 1; s_data = {8'h00, 8'h00, 8'h05, 8'h00};
        tick();
        cfg_we = 1; cfg_neuron = 1; cfg_addr = 8'h05; cfg_data = 1;
        tbl[1][8'h05] = 1;
        tick();
        cfg_we = 0; s_valid = 0;
        chk("t4_v_old", m_valid, 1);
        chk("t4_bit1_old", m_data[1], 0);
        tick();
        chk("t4_v_new", m_valid, 1);
        chk("t4_bit1_new", m_data[1], 1);
        drain();

        // Test 5: bad neuron index
        cfg_write(4, $urandom_range(0, 255), 1);
        chk("t5_err_pulse", cfg_err, 1);
        tick();
        chk("t5_err_clear", cfg_err, 0);
        cfg_write(7, $urandom_range(0, 255), 1);
        chk("t5_err_pulse7", cfg_err, 1);
        random_traffic(40);

        // Test 6: reset mid-stream
        s_valid = 1; s_data = $urandom;
        tick();
        s_data = $urandom;
        tick();
        s_valid = 0;
        chk("t6_inflight", m_valid, 1);
        rst = 1;
        #1;
        chk("t6_m_valid_drop", m_valid, 0);
        chk("t6_m_data_zero", m_data, 0);
        chk("t6_s_ready_rst", s_ready, 0);
        for (int n = 0; n < 4; n++) for (int a = 0; a < 256; a++) tbl[n][a] = 0;
        tick();
        rst = 0;
        repeat (4) begin
            tick();
            chk("t6_no_stale", m_valid, 0);
        end
        s_valid = 1; s_data = $urandom;
        tick();
        s_valid = 0;
        tick();
        chk("t6_post_v", m_valid, 1);
        chk("t6_tables_zero", m_data, 0);
        random_traffic(40);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
